// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit for the 5-stage LEGv8 core: ID-stage decode, branch
// resolution with EX flag forwarding, load-use stall, NZVC register, and the
// control bundle carried through ID/EX, EX/MEM and MEM/WB.
module ctrl_pipe_unit #(
    parameter int ALUOP_W    = 3,
    parameter int XFER_W     = 4,
    parameter int REG_W      = 5,
    parameter int BCOND_FULL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               id_valid,
    input  logic [10:0]        id_opcode,
    input  logic [REG_W-1:0]   id_cond,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [REG_W-1:0]   id_rn,
    input  logic [REG_W-1:0]   id_rm,
    input  logic               id_zero,
    input  logic               ex_n,
    input  logic               ex_z,
    input  logic               ex_v,
    input  logic               ex_c,
    output logic               reg2loc,
    output logic               imm_sel,
    output logic               br_taken,
    output logic               uncond_br,
    output logic               br_reg,
    output logic               stall,
    output logic               flush_if,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_flagset,
    output logic [REG_W-1:0]   ex_rd,
    output logic               mem_read,
    output logic               mem_write,
    output logic [XFER_W-1:0]  mem_xfer,
    output logic [REG_W-1:0]   mem_rd,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic               wb_link,
    output logic [REG_W-1:0]   wb_rd,
    output logic [3:0]         flags_q
);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b011);
    localparam logic [XFER_W-1:0]  XFER_DW   = XFER_W'(4'b1000);
    localparam logic [REG_W-1:0]   LINK_REG  = REG_W'(30);
    localparam logic [REG_W-1:0]   ZERO_REG  = {REG_W{1'b1}};

    // ---------------- ID-stage decode ----------------
    logic               dec_reg_write, dec_alu_src, dec_imm_sel, dec_reg2loc;
    logic               dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_flagset;
    logic               dec_uncond, dec_br_reg, dec_link, dec_cbz, dec_bcond;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [XFER_W-1:0]  dec_xfer;
    logic [REG_W-1:0]   dec_rd;
    logic               use_rn, use_rm, use_rd;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_imm_sel    = 1'b0;
        dec_reg2loc    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_flagset    = 1'b0;
        dec_uncond     = 1'b0;
        dec_br_reg     = 1'b0;
        dec_link       = 1'b0;
        dec_cbz        = 1'b0;
        dec_bcond      = 1'b0;
        dec_alu_op     = '0;
        dec_xfer       = '0;
        dec_rd         = '0;
        use_rn         = 1'b0;
        use_rm         = 1'b0;
        use_rd         = 1'b0;
        if (id_valid) begin
            casez (id_opcode)
                11'b10001011000, 11'b10101011000: begin
                    dec_reg_write = 1'b1;
                    dec_alu_op    = ALU_ADD;
                    dec_flagset   = id_opcode[8];
                    dec_rd        = id_rd;
                    use_rn        = 1'b1;
                    use_rm        = 1'b1;
                end
                11'b11001011000, 11'b11101011000: begin
                    dec_reg_write = 1'b1;
                    dec_alu_op    = ALU_SUB;
                    dec_flagset   = id_opcode[8];
                    dec_rd        = id_rd;
                    use_rn        = 1'b1;
                    use_rm        = 1'b1;
                end
                11'b1001000100?: begin
                    dec_reg_write = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_imm_sel   = 1'b1;
                    dec_reg2loc   = 1'b1;
                    dec_alu_op    = ALU_ADD;
                    dec_rd        = id_rd;
                    use_rn        = 1'b1;
                end
                11'b11111000010: begin
                    dec_reg_write  = 1'b1;
                    dec_alu_src    = 1'b1;
                    dec_mem_read   = 1'b1;
                    dec_mem_to_reg = 1'b1;
                    dec_alu_op     = ALU_ADD;
                    dec_xfer       = XFER_DW;
                    dec_rd         = id_rd;
                    use_rn         = 1'b1;
                end
                11'b11111000000: begin
                    dec_reg2loc   = 1'b1;
                    dec_alu_src   = 1'b1;
                    dec_mem_write = 1'b1;
                    dec_alu_op    = ALU_ADD;
                    dec_xfer      = XFER_DW;
                    dec_rd        = id_rd;
                    use_rn        = 1'b1;
                    use_rd        = 1'b1;
                end
                11'b000101?????: begin
                    dec_uncond = 1'b1;
                    dec_rd     = id_rd;
                end
                11'b100101?????: begin
                    dec_uncond    = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_link      = 1'b1;
                    dec_rd        = LINK_REG;
                end
                11'b11010110000: begin
                    dec_reg2loc = 1'b1;
                    dec_br_reg  = 1'b1;
                    dec_rd      = id_rd;
                    use_rn      = 1'b1;
                end
                11'b10110100???: begin
                    dec_reg2loc = 1'b1;
                    dec_cbz     = 1'b1;
                    dec_rd      = id_rd;
                    use_rn      = 1'b1;
                    use_rd      = 1'b1;
                end
                11'b01010100???: begin
                    dec_bcond = 1'b1;
                    dec_rd    = id_rd;
                end
                default: ;
            endcase
        end
    end

    // ---------------- condition evaluation ----------------
    function automatic logic cond_fn(input logic [3:0] code, input logic [3:0] f);
        logic n, z, v, c;
        {n, z, v, c} = f;
        case (code)
            4'b0000: cond_fn = z;
            4'b0001: cond_fn = !z;
            4'b0010: cond_fn = c;
            4'b0011: cond_fn = !c;
            4'b0100: cond_fn = n;
            4'b0101: cond_fn = !n;
            4'b0110: cond_fn = v;
            4'b0111: cond_fn = !v;
            4'b1000: cond_fn = c & !z;
            4'b1001: cond_fn = !(c & !z);
            4'b1010: cond_fn = (n == v);
            4'b1011: cond_fn = (n != v);
            4'b1100: cond_fn = !z & (n == v);
            4'b1101: cond_fn = !(!z & (n == v));
            default: cond_fn = 1'b1;
        endcase
    endfunction

    logic               id_ex_flagset_reg;
    logic [3:0]         flags_reg;
    logic [3:0]         flags_eff;
    logic [15:0]        cond_vec;

    // A flag-setting instruction still in EX has not reached the register yet.
    assign flags_eff = id_ex_flagset_reg ? {ex_n, ex_z, ex_v, ex_c} : flags_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cond
            if (BCOND_FULL != 0 || gi == 11) begin : g_on
                assign cond_vec[gi] = cond_fn(4'(gi), flags_eff);
            end else begin : g_off
                assign cond_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // ---------------- load-use hazard ----------------
    logic                id_ex_mem_read_reg;
    logic [REG_W-1:0]    id_ex_rd_reg;
    logic [REG_W-1:0]    src_idx [3];
    logic [2:0]          src_use;
    logic [2:0]          src_hit;

    assign src_idx[0] = id_rn;
    assign src_idx[1] = id_rm;
    assign src_idx[2] = id_rd;
    assign src_use    = {use_rd, use_rm, use_rn};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] & (src_idx[gi] == id_ex_rd_reg);
        end
    endgenerate

    assign stall = id_ex_mem_read_reg & (id_ex_rd_reg != ZERO_REG) & (|src_hit);

    logic dec_taken;
    assign dec_taken = dec_uncond | dec_br_reg | (dec_cbz & id_zero)
                     | (dec_bcond & cond_vec[id_cond[3:0]]);

    assign reg2loc   = dec_reg2loc;
    assign imm_sel   = dec_imm_sel;
    assign uncond_br = dec_uncond;
    assign br_reg    = dec_br_reg;
    assign br_taken  = dec_taken & ~stall;
    assign flush_if  = br_taken & ~stall & ~hold;

    logic unused_cond_hi;
    assign unused_cond_hi = ^id_cond[REG_W-1:4];

    // ---------------- pipeline registers ----------------
    logic [ALUOP_W-1:0] id_ex_alu_op_reg, id_ex_alu_op_next;
    logic               id_ex_alu_src_reg, id_ex_alu_src_next;
    logic               id_ex_flagset_next;
    logic               id_ex_mem_read_next;
    logic               id_ex_mem_write_reg, id_ex_mem_write_next;
    logic [XFER_W-1:0]  id_ex_xfer_reg, id_ex_xfer_next;
    logic               id_ex_reg_write_reg, id_ex_reg_write_next;
    logic               id_ex_mem_to_reg_reg, id_ex_mem_to_reg_next;
    logic               id_ex_link_reg, id_ex_link_next;
    logic [REG_W-1:0]   id_ex_rd_next;

    logic               ex_mem_mem_read_reg, ex_mem_mem_write_reg;
    logic [XFER_W-1:0]  ex_mem_xfer_reg;
    logic               ex_mem_reg_write_reg, ex_mem_mem_to_reg_reg, ex_mem_link_reg;
    logic [REG_W-1:0]   ex_mem_rd_reg;

    logic               mem_wb_reg_write_reg, mem_wb_mem_to_reg_reg, mem_wb_link_reg;
    logic [REG_W-1:0]   mem_wb_rd_reg;

    // A stalled instruction stays in ID; EX receives an all-zero bubble.
    always_comb begin
        id_ex_alu_op_next     = stall ? '0   : dec_alu_op;
        id_ex_alu_src_next    = stall ? 1'b0 : dec_alu_src;
        id_ex_flagset_next    = stall ? 1'b0 : dec_flagset;
        id_ex_mem_read_next   = stall ? 1'b0 : dec_mem_read;
        id_ex_mem_write_next  = stall ? 1'b0 : dec_mem_write;
        id_ex_xfer_next       = stall ? '0   : dec_xfer;
        id_ex_reg_write_next  = stall ? 1'b0 : dec_reg_write;
        id_ex_mem_to_reg_next = stall ? 1'b0 : dec_mem_to_reg;
        id_ex_link_next       = stall ? 1'b0 : dec_link;
        id_ex_rd_next         = stall ? '0   : dec_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_alu_op_reg      <= '0;
            id_ex_alu_src_reg     <= 1'b0;
            id_ex_flagset_reg     <= 1'b0;
            id_ex_mem_read_reg    <= 1'b0;
            id_ex_mem_write_reg   <= 1'b0;
            id_ex_xfer_reg        <= '0;
            id_ex_reg_write_reg   <= 1'b0;
            id_ex_mem_to_reg_reg  <= 1'b0;
            id_ex_link_reg        <= 1'b0;
            id_ex_rd_reg          <= '0;
            ex_mem_mem_read_reg   <= 1'b0;
            ex_mem_mem_write_reg  <= 1'b0;
            ex_mem_xfer_reg       <= '0;
            ex_mem_reg_write_reg  <= 1'b0;
            ex_mem_mem_to_reg_reg <= 1'b0;
            ex_mem_link_reg       <= 1'b0;
            ex_mem_rd_reg         <= '0;
            mem_wb_reg_write_reg  <= 1'b0;
            mem_wb_mem_to_reg_reg <= 1'b0;
            mem_wb_link_reg       <= 1'b0;
            mem_wb_rd_reg         <= '0;
            flags_reg             <= 4'b0000;
        end else if (!hold) begin
            id_ex_alu_op_reg      <= id_ex_alu_op_next;
            id_ex_alu_src_reg     <= id_ex_alu_src_next;
            id_ex_flagset_reg     <= id_ex_flagset_next;
            id_ex_mem_read_reg    <= id_ex_mem_read_next;
            id_ex_mem_write_reg   <= id_ex_mem_write_next;
            id_ex_xfer_reg        <= id_ex_xfer_next;
            id_ex_reg_write_reg   <= id_ex_reg_write_next;
            id_ex_mem_to_reg_reg  <= id_ex_mem_to_reg_next;
            id_ex_link_reg        <= id_ex_link_next;
            id_ex_rd_reg          <= id_ex_rd_next;
            ex_mem_mem_read_reg   <= id_ex_mem_read_reg;
            ex_mem_mem_write_reg  <= id_ex_mem_write_reg;
            ex_mem_xfer_reg       <= id_ex_xfer_reg;
            ex_mem_reg_write_reg  <= id_ex_reg_write_reg;
            ex_mem_mem_to_reg_reg <= id_ex_mem_to_reg_reg;
            ex_mem_link_reg       <= id_ex_link_reg;
            ex_mem_rd_reg         <= id_ex_rd_reg;
            mem_wb_reg_write_reg  <= ex_mem_reg_write_reg;
            mem_wb_mem_to_reg_reg <= ex_mem_mem_to_reg_reg;
            mem_wb_link_reg       <= ex_mem_link_reg;
            mem_wb_rd_reg         <= ex_mem_rd_reg;
            if (id_ex_flagset_reg) begin
                flags_reg <= {ex_n, ex_z, ex_v, ex_c};
            end
        end
    end

    assign ex_alu_op     = id_ex_alu_op_reg;
    assign ex_alu_src    = id_ex_alu_src_reg;
    assign ex_flagset    = id_ex_flagset_reg;
    assign ex_rd         = id_ex_rd_reg;
    assign mem_read      = ex_mem_mem_read_reg;
    assign mem_write     = ex_mem_mem_write_reg;
    assign mem_xfer      = ex_mem_xfer_reg;
    assign mem_rd        = ex_mem_rd_reg;
    assign wb_reg_write  = mem_wb_reg_write_reg;
    assign wb_mem_to_reg = mem_wb_mem_to_reg_reg;
    assign wb_link       = mem_wb_link_reg;
    assign wb_rd         = mem_wb_rd_reg;
    assign flags_q       = flags_reg;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: decode, pipeline latency, load-use stall,
// flag forwarding, B.cond subset variant, hold and reset interaction.
module tb_ctrl_pipe_unit;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BL   = 11'b10010100000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_BCND = 11'b01010100000;

    logic        clk = 1'b0;
    logic        reset, hold, id_valid, id_zero;
    logic [10:0] id_opcode;
    logic [4:0]  id_cond, id_rd, id_rn, id_rm;
    logic        ex_n, ex_z, ex_v, ex_c;

    logic       reg2loc, imm_sel, br_taken, uncond_br, br_reg, stall, flush_if;
    logic [2:0] ex_alu_op;
    logic       ex_alu_src, ex_flagset, mem_read, mem_write;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic [3:0] mem_xfer, flags_q;
    logic       wb_reg_write, wb_mem_to_reg, wb_link;

    logic       l_reg2loc, l_imm_sel, l_br_taken, l_uncond_br, l_br_reg, l_stall, l_flush_if;
    logic [2:0] l_ex_alu_op;
    logic       l_ex_alu_src, l_ex_flagset, l_mem_read, l_mem_write;
    logic [4:0] l_ex_rd, l_mem_rd, l_wb_rd;
    logic [3:0] l_mem_xfer, l_flags_q;
    logic       l_wb_reg_write, l_wb_mem_to_reg, l_wb_link;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.BCOND_FULL(1)) dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_cond(id_cond), .id_rd(id_rd), .id_rn(id_rn),
        .id_rm(id_rm), .id_zero(id_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v),
        .ex_c(ex_c), .reg2loc(reg2loc), .imm_sel(imm_sel), .br_taken(br_taken),
        .uncond_br(uncond_br), .br_reg(br_reg), .stall(stall), .flush_if(flush_if),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_flagset(ex_flagset),
        .ex_rd(ex_rd), .mem_read(mem_read), .mem_write(mem_write),
        .mem_xfer(mem_xfer), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link), .wb_rd(wb_rd),
        .flags_q(flags_q)
    );

    ctrl_pipe_unit #(.BCOND_FULL(0)) dut_lt (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_cond(id_cond), .id_rd(id_rd), .id_rn(id_rn),
        .id_rm(id_rm), .id_zero(id_zero), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v),
        .ex_c(ex_c), .reg2loc(l_reg2loc), .imm_sel(l_imm_sel), .br_taken(l_br_taken),
        .uncond_br(l_uncond_br), .br_reg(l_br_reg), .stall(l_stall), .flush_if(l_flush_if),
        .ex_alu_op(l_ex_alu_op), .ex_alu_src(l_ex_alu_src), .ex_flagset(l_ex_flagset),
        .ex_rd(l_ex_rd), .mem_read(l_mem_read), .mem_write(l_mem_write),
        .mem_xfer(l_mem_xfer), .mem_rd(l_mem_rd), .wb_reg_write(l_wb_reg_write),
        .wb_mem_to_reg(l_wb_mem_to_reg), .wb_link(l_wb_link), .wb_rd(l_wb_rd),
        .flags_q(l_flags_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] cond);
        id_valid  = 1'b1;
        id_opcode = op;
        id_rd     = rd;
        id_rn     = rn;
        id_rm     = rm;
        id_cond   = cond;
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_opcode = '0;
        #1;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; id_valid = 1'b0; id_zero = 1'b0;
        id_opcode = '0; id_cond = '0; id_rd = '0; id_rn = '0; id_rm = '0;
        ex_n = 1'b0; ex_z = 1'b0; ex_v = 1'b0; ex_c = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_ex_alu_op", ex_alu_op, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_wb_reg_write", wb_reg_write, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_stall", stall, 0);

        // ADD X1,X2,X3 through the pipe
        instr(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0);
        chk("add_reg2loc", reg2loc, 0);
        chk("add_br_taken", br_taken, 0);
        tick();
        chk("add_ex_alu_op", ex_alu_op, 3'b010);
        chk("add_ex_rd", ex_rd, 1);
        idle();
        tick();
        chk("add_mem_read", mem_read, 0);
        chk("add_mem_write", mem_write, 0);
        chk("add_mem_rd", mem_rd, 1);
        tick();
        chk("add_wb_reg_write", wb_reg_write, 1);
        chk("add_wb_rd", wb_rd, 1);

        // LDUR X5 then dependent ADD X6,X5,X7
        instr(OP_LDUR, 5'd5, 5'd9, 5'd0, 5'd0);
        chk("ldur_no_stall", stall, 0);
        tick();
        instr(OP_ADD, 5'd6, 5'd5, 5'd7, 5'd0);
        chk("lu_stall", stall, 1);
        chk("lu_flush", flush_if, 0);
        tick();
        chk("lu_bubble_op", ex_alu_op, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_mem_read", mem_read, 1);
        chk("lu_mem_rd", mem_rd, 5);
        chk("lu_mem_xfer", mem_xfer, 4'b1000);
        chk("lu_stall_cleared", stall, 0);
        tick();
        chk("lu_late_op", ex_alu_op, 3'b010);
        chk("lu_late_rd", ex_rd, 6);
        chk("lu_late_stall", stall, 0);

        // Load to X31 never stalls; STUR Rd hazard under hold keeps stall
        instr(OP_LDUR, 5'd31, 5'd9, 5'd0, 5'd0);
        tick();
        instr(OP_ADD, 5'd6, 5'd31, 5'd31, 5'd0);
        chk("xzr_no_stall", stall, 0);
        instr(OP_LDUR, 5'd5, 5'd1, 5'd0, 5'd0);
        tick();
        instr(OP_STUR, 5'd5, 5'd2, 5'd0, 5'd0);
        chk("stur_rd_stall", stall, 1);
        hold = 1'b1;
        tick();
        chk("hold_stall_kept", stall, 1);
        chk("hold_ex_rd", ex_rd, 5);
        hold = 1'b0;
        tick();
        chk("post_hold_bubble", ex_rd, 0);
        chk("post_hold_stall", stall, 0);
        idle();

        // SUBS in EX (N=1,V=0) with B.LT in ID
        instr(OP_SUBS, 5'd1, 5'd2, 5'd3, 5'd0);
        tick();
        ex_n = 1'b1;
        instr(OP_BCND, 5'd0, 5'd0, 5'd0, 5'd11);
        chk("lt_fwd_taken", br_taken, 1);
        chk("lt_fwd_flush", flush_if, 1);
        chk("lt_uncond", uncond_br, 0);
        chk("lt_fwd_taken_lt", l_br_taken, 1);
        tick();
        ex_n = 1'b0;
        #1;
        chk("subs_flags", flags_q, 4'b1000);
        chk("lt_reg_taken", br_taken, 1);

        // ADDS sets Z; B.EQ forwarded then from the register
        instr(OP_ADDS, 5'd2, 5'd3, 5'd4, 5'd0);
        tick();
        ex_z = 1'b1;
        instr(OP_BCND, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("eq_fwd_full", br_taken, 1);
        chk("eq_fwd_lt_only", l_br_taken, 0);
        tick();
        ex_z = 1'b0;
        #1;
        chk("adds_flags", flags_q, 4'b0100);
        chk("eq_reg_full", br_taken, 1);
        chk("eq_reg_lt_only", l_br_taken, 0);
        id_cond = 5'd1; #1;
        chk("ne_taken", br_taken, 0);
        id_cond = 5'd14; #1;
        chk("al_full", br_taken, 1);
        chk("al_lt_only", l_br_taken, 0);
        id_cond = 5'd12; #1;
        chk("gt_taken", br_taken, 0);
        id_cond = 5'd10; #1;
        chk("ge_taken", br_taken, 1);
        id_cond = 5'd11; #1;
        chk("lt_false_lt_only", l_br_taken, 0);

        // BL links to X30
        instr(OP_BL, 5'd7, 5'd0, 5'd0, 5'd0);
        chk("bl_taken", br_taken, 1);
        chk("bl_uncond", uncond_br, 1);
        chk("bl_flush", flush_if, 1);
        tick();
        idle();
        tick();
        tick();
        chk("bl_wb_reg_write", wb_reg_write, 1);
        chk("bl_wb_link", wb_link, 1);
        chk("bl_wb_rd", wb_rd, 30);
        chk("bl_wb_mem_to_reg", wb_mem_to_reg, 0);

        // Opcode 0 decodes to a bubble
        instr(11'h000, 5'd3, 5'd4, 5'd5, 5'd0);
        chk("op0_br_taken", br_taken, 0);
        chk("op0_reg2loc", reg2loc, 0);
        chk("op0_imm_sel", imm_sel, 0);
        chk("op0_br_reg", br_reg, 0);
        tick();
        chk("op0_ex_alu_op", ex_alu_op, 0);
        chk("op0_ex_rd", ex_rd, 0);
        chk("op0_ex_alu_src", ex_alu_src, 0);

        // CBZ, BR, ADDI decode
        id_zero = 1'b1;
        instr(OP_CBZ, 5'd4, 5'd1, 5'd0, 5'd0);
        chk("cbz_taken", br_taken, 1);
        chk("cbz_reg2loc", reg2loc, 1);
        id_zero = 1'b0; #1;
        chk("cbz_not_taken", br_taken, 0);
        instr(OP_BR, 5'd0, 5'd3, 5'd0, 5'd0);
        chk("br_br_reg", br_reg, 1);
        chk("br_taken", br_taken, 1);
        instr(OP_ADDI, 5'd9, 5'd1, 5'd0, 5'd0);
        chk("addi_imm_sel", imm_sel, 1);
        chk("addi_reg2loc", reg2loc, 1);
        tick();
        chk("addi_alu_src", ex_alu_src, 1);
        chk("addi_ex_rd", ex_rd, 9);

        // Hold two cycles, reset asserted on the second
        instr(OP_ADD, 5'd4, 5'd1, 5'd2, 5'd0);
        tick();
        instr(OP_SUBS, 5'd8, 5'd1, 5'd2, 5'd0);
        tick();
        hold = 1'b1;
        ex_n = 1'b1;
        ex_c = 1'b1;
        instr(OP_STUR, 5'd3, 5'd1, 5'd0, 5'd0);
        tick();
        chk("hold_ex_rd_frozen", ex_rd, 8);
        chk("hold_mem_rd_frozen", mem_rd, 4);
        chk("hold_flagset", ex_flagset, 1);
        chk("hold_flags_frozen", flags_q, 4'b0100);
        reset = 1'b1;
        tick();
        chk("hrst_ex_rd", ex_rd, 0);
        chk("hrst_mem_rd", mem_rd, 0);
        chk("hrst_wb_rd", wb_rd, 0);
        chk("hrst_wb_reg_write", wb_reg_write, 0);
        chk("hrst_ex_flagset", ex_flagset, 0);
        chk("hrst_flags", flags_q, 0);
        reset = 1'b0;
        hold = 1'b0;
        ex_n = 1'b0;
        ex_c = 1'b0;
        idle();
        tick();
        chk("after_rst_wb_reg_write", wb_reg_write, 0);
        chk("after_rst_mem_write", mem_write, 0);
        chk("after_rst_mem_read", mem_read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
